// File: rtl/pc_redirect_unit_pkg.sv
// Shared defaults and encodings for the fetch PC / redirect slice.
// Imported by the target calculator and the redirect unit.
package pc_redirect_unit_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int IMM_W_DEF = 16;
  localparam int INC_DEF = 2;
  localparam int ALIGN_DEF = 1;
  localparam int RESET_PC_DEF = 0;

  localparam logic BR_REL = 1'b0;
  localparam logic BR_ABS = 1'b1;

endpackage

// File: rtl/pc_target_calc.sv
// Branch/jump target arithmetic: sign-extend, add, align-check.
// Purely combinational; wraps modulo 2^WIDTH.
module pc_target_calc
  import pc_redirect_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int IMM_W = IMM_W_DEF,
  parameter int INC = INC_DEF,
  parameter int ALIGN = ALIGN_DEF
) (
  input  logic [WIDTH-1:0] br_pc,
  input  logic [IMM_W-1:0] br_imm,
  input  logic             br_abs,
  output logic [WIDTH-1:0] tgt,
  output logic             mis
);

  localparam logic [WIDTH-1:0] AMASK =
    WIDTH'((64'd1 << ALIGN) - 64'd1);
  localparam logic [WIDTH-1:0] INCW = WIDTH'(INC);

  logic [WIDTH-1:0] sext;
  logic [WIDTH-1:0] raw;

  // sign-extend the immediate, pick base, then strip align bits
  always_comb begin
    sext = {WIDTH{br_imm[IMM_W-1]}};
    sext[IMM_W-1:0] = br_imm;
    if (br_abs == BR_ABS)
      raw = sext;
    else
      raw = br_pc + INCW + sext;
    mis = |(raw & AMASK);
    tgt = raw & ~AMASK;
  end

endmodule

// File: rtl/pc_redirect_unit.sv
// Fetch PC register with a one-entry registered redirect stage.
// Execute hands over taken branches; fetch sees pc and flush.
module pc_redirect_unit
  import pc_redirect_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int IMM_W = IMM_W_DEF,
  parameter int INC = INC_DEF,
  parameter int ALIGN = ALIGN_DEF,
  parameter int RESET_PC = RESET_PC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic             br_abs,
  input  logic [WIDTH-1:0] br_pc,
  input  logic [IMM_W-1:0] br_imm,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_next_seq,
  output logic             flush,
  output logic             misalign
);

  logic             tgt_v;
  logic [WIDTH-1:0] tgt_q;
  logic             tgt_mis;
  logic [WIDTH-1:0] calc_tgt;
  logic             calc_mis;
  logic             accept;

  pc_target_calc #(
    .WIDTH(WIDTH),
    .IMM_W(IMM_W),
    .INC(INC),
    .ALIGN(ALIGN)
  ) u_calc (
    .br_pc(br_pc),
    .br_imm(br_imm),
    .br_abs(br_abs),
    .tgt(calc_tgt),
    .mis(calc_mis)
  );

  // handshake and redirect visibility from registered state
  always_comb begin
    pc_next_seq = pc + WIDTH'(INC);
    br_ready = !tgt_v || !stall;
    accept = br_valid && br_ready;
    flush = tgt_v && !stall;
    misalign = flush && tgt_mis;
  end

  // pc advances or redirects unless stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= WIDTH'(RESET_PC);
    end else if (!stall) begin
      pc <= tgt_v ? tgt_q : pc_next_seq;
    end
  end

  // pending slot: a new accept may overwrite while consuming
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt_v <= 1'b0;
      tgt_q <= '0;
      tgt_mis <= 1'b0;
    end else if (accept) begin
      tgt_v <= 1'b1;
      tgt_q <= calc_tgt;
      tgt_mis <= calc_mis;
    end else if (flush) begin
      tgt_v <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Self-checking bench for pc_redirect_unit (16-bit, INC=2, ALIGN=1).
// Directed scenarios plus randomized traffic against a reference model.
module tb_pc_redirect_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        br_valid;
  logic        br_ready;
  logic        br_abs;
  logic [15:0] br_pc;
  logic [15:0] br_imm;
  logic [15:0] pc;
  logic [15:0] pc_next_seq;
  logic        flush;
  logic        misalign;

  int n_cmp = 0;
  int n_bad = 0;

  int m_pc;
  bit m_pv;
  int m_pt;
  bit m_pm;

  pc_redirect_unit dut (
    .clk(clk),
    .rst_n(rst_n),
    .stall(stall),
    .br_valid(br_valid),
    .br_ready(br_ready),
    .br_abs(br_abs),
    .br_pc(br_pc),
    .br_imm(br_imm),
    .pc(pc),
    .pc_next_seq(pc_next_seq),
    .flush(flush),
    .misalign(misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int raw_target(bit abs, logic [15:0] bpc,
                                    logic [15:0] imm);
    int s;
    s = int'($signed(imm));
    if (abs) return s & 32'hFFFF;
    return (int'(bpc) + 2 + s) & 32'hFFFF;
  endfunction

  task automatic model_reset();
    m_pc = 0;
    m_pv = 0;
    m_pt = 0;
    m_pm = 0;
  endtask

  // advance the model with the current inputs, then cross one cycle
  task automatic tick();
    bit rdy;
    bit acc;
    int raw;
    rdy = !m_pv || !stall;
    acc = br_valid && rdy;
    raw = raw_target(br_abs, br_pc, br_imm);
    if (!stall) m_pc = m_pv ? m_pt : ((m_pc + 2) & 32'hFFFF);
    if (acc) begin
      m_pv = 1;
      m_pt = raw & 32'hFFFE;
      m_pm = raw[0];
    end else if (!stall) begin
      m_pv = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    stall = 0;
    br_valid = 0;
    br_abs = 0;
    br_pc = '0;
    br_imm = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (pc !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset_pc: got %h want 0000", pc);
    end
    n_cmp++;
    if (flush !== 1'b0 || misalign !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_flush: got %b%b want 00", flush, misalign);
    end
    n_cmp++;
    if (br_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready: got %b want 1", br_ready);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++;
      if (pc !== 16'(2 * i) || flush !== 1'b0 || br_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL seq_%0d: pc=%h flush=%b rdy=%b want pc=%h 0 1",
                 i, pc, flush, br_ready, 16'(2 * i));
      end
      n_cmp++;
      if (pc_next_seq !== 16'(2 * i + 2)) begin
        n_bad++;
        $display("FAIL seq_next_%0d: got %h want %h",
                 i, pc_next_seq, 16'(2 * i + 2));
      end
      if (i < 4) tick();
    end
  endtask

  task automatic test_relative();
    br_valid = 1;
    br_abs = 0;
    br_pc = 16'h0010;
    br_imm = 16'hFFFA;
    #1;
    n_cmp++;
    if (br_ready !== 1'b1 || flush !== 1'b0) begin
      n_bad++;
      $display("FAIL rel_accept: rdy=%b flush=%b want 1 0", br_ready, flush);
    end
    tick();
    idle_inputs();
    #1;
    n_cmp++;
    if (flush !== 1'b1 || misalign !== 1'b0) begin
      n_bad++;
      $display("FAIL rel_flush: got %b%b want 10", flush, misalign);
    end
    tick();
    #1;
    n_cmp++;
    if (pc !== 16'h000C || flush !== 1'b0) begin
      n_bad++;
      $display("FAIL rel_pc: pc=%h flush=%b want 000c 0", pc, flush);
    end
  endtask

  task automatic test_abs_misalign();
    br_valid = 1;
    br_abs = 1;
    br_imm = 16'h1235;
    tick();
    idle_inputs();
    #1;
    n_cmp++;
    if (flush !== 1'b1 || misalign !== 1'b1) begin
      n_bad++;
      $display("FAIL abs_mis: got %b%b want 11", flush, misalign);
    end
    tick();
    #1;
    n_cmp++;
    if (pc !== 16'h1234 || misalign !== 1'b0) begin
      n_bad++;
      $display("FAIL abs_pc: pc=%h mis=%b want 1234 0", pc, misalign);
    end
  endtask

  task automatic test_stall_backpressure();
    logic [15:0] held;
    br_valid = 1;
    br_abs = 1;
    br_imm = 16'h0100;
    tick();
    held = pc;
    stall = 1;
    br_imm = 16'h0200;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (br_ready !== 1'b0 || flush !== 1'b0 || pc !== held) begin
        n_bad++;
        $display("FAIL stall_hold_%0d: rdy=%b flush=%b pc=%h want 0 0 %h",
                 i, br_ready, flush, pc, held);
      end
      tick();
    end
    stall = 0;
    #1;
    n_cmp++;
    if (flush !== 1'b1 || br_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL stall_release: flush=%b rdy=%b want 1 1", flush, br_ready);
    end
    tick();
    idle_inputs();
    #1;
    n_cmp++;
    if (pc !== 16'h0100 || flush !== 1'b1) begin
      n_bad++;
      $display("FAIL stall_first: pc=%h flush=%b want 0100 1", pc, flush);
    end
    tick();
    #1;
    n_cmp++;
    if (pc !== 16'h0200 || flush !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_second: pc=%h flush=%b want 0200 0", pc, flush);
    end
  endtask

  task automatic test_wrap();
    br_valid = 1;
    br_abs = 1;
    br_imm = 16'hFFFE;
    tick();
    idle_inputs();
    tick();
    #1;
    n_cmp++;
    if (pc !== 16'hFFFE || pc_next_seq !== 16'h0000) begin
      n_bad++;
      $display("FAIL wrap_pre: pc=%h nxt=%h want fffe 0000", pc, pc_next_seq);
    end
    tick();
    #1;
    n_cmp++;
    if (pc !== 16'h0000) begin
      n_bad++;
      $display("FAIL wrap_pc: got %h want 0000", pc);
    end
    br_valid = 1;
    br_abs = 0;
    br_pc = 16'hFFFC;
    br_imm = 16'h0004;
    tick();
    idle_inputs();
    tick();
    #1;
    n_cmp++;
    if (pc !== 16'h0002) begin
      n_bad++;
      $display("FAIL wrap_rel: got %h want 0002", pc);
    end
  endtask

  task automatic test_random();
    bit hold;
    idle_inputs();
    for (int i = 0; i < 300; i++) begin
      #1;
      n_cmp++;
      if (pc !== 16'(m_pc) || flush !== (m_pv && !stall) ||
          misalign !== (m_pv && !stall && m_pm) ||
          br_ready !== (!m_pv || !stall)) begin
        n_bad++;
        $display("FAIL rand_%0d: pc=%h f=%b m=%b r=%b want %h %b %b %b",
                 i, pc, flush, misalign, br_ready, 16'(m_pc),
                 m_pv && !stall, m_pv && !stall && m_pm, !m_pv || !stall);
      end
      hold = br_valid && !(!m_pv || !stall);
      tick();
      stall = ($urandom_range(0, 9) < 3);
      if (!hold) begin
        br_valid = ($urandom_range(0, 9) < 4);
        br_abs = $urandom_range(0, 1) != 0;
        br_pc = 16'($urandom);
        br_imm = 16'($urandom);
      end
    end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_async_reset();
    br_valid = 1;
    br_abs = 1;
    br_imm = 16'h4444;
    tick();
    idle_inputs();
    stall = 1;
    tick();
    #3;
    rst_n = 0;
    #1;
    n_cmp++;
    if (pc !== 16'h0000 || flush !== 1'b0 || br_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL async_rst: pc=%h flush=%b rdy=%b want 0000 0 1",
               pc, flush, br_ready);
    end
    @(negedge clk);
    model_reset();
    stall = 0;
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (pc !== 16'(2 * i) || flush !== 1'b0) begin
        n_bad++;
        $display("FAIL post_rst_%0d: pc=%h flush=%b want %h 0",
                 i, pc, flush, 16'(2 * i));
      end
      tick();
    end
  endtask

  initial begin
    rst_n = 1;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_sequential();
    test_relative();
    test_abs_misalign();
    test_stall_backpressure();
    test_wrap();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
